sbox_share_sched: RTL and testbench

- Time-multiplexes one shared, fixed-latency S-box datapath (the per-bit generated sub-lane array) among NUM_REQ requesters.
- Requesters present WIDTH-bit words over valid/ready.
- The scheduler grants one request per cycle, round-robin, and tags each in-flight word with its requester ID.
- Results are collected into a response FIFO and returned with backpressure, so the non-stallable datapath never loses data.

---
 rtl/sbox_share_sched.sv | 179 +++++++++++++++++
 tb/tb_sbox_share_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_sched.sv
// sbox_share_sched
//   Shares one fixed-latency, non-stallable S-box datapath among NUM_REQ
//   requesters. A round-robin arbiter grants at most one request per cycle.
//   A {valid, id} shift pipe tracks each issued word through the datapath.
//   Results land in a response FIFO and leave it under consumer backpressure.
//   A credit counter (FIFO occupancy + words in flight) blocks issue whenever
//   a result could arrive with no free FIFO slot.
//
// Ports
//   clk_i, rst_ni   clock (rising edge) and asynchronous active-low reset
//   req_valid_i     per-requester request valid
//   req_data_i      request words, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o     one-hot accept, at most one bit set per cycle
//   sbox_valid_o    word issued to the shared datapath this cycle
//   sbox_data_o     word to the datapath (0 when nothing is issued)
//   sbox_data_i     datapath result, valid LATENCY cycles after issue
//   rsp_valid_o     response FIFO head valid
//   rsp_id_o        requester index of the head response
//   rsp_data_o      head result word
//   rsp_ready_i     consumer accepts the head
//
// Handshake semantics (both the request side and the response side):
//   A transfer happens in exactly the cycles where valid & ready are both
//   high. Once the source raises valid, it holds valid and data stable until
//   the transfer. Ready never depends on the data bus. Here req_ready_o may
//   depend on req_valid_i and on rsp_ready_i, through the same-cycle credit
//   release.
module sbox_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     sbox_valid_o,
  output logic [WIDTH-1:0]         sbox_data_o,
  input  logic [WIDTH-1:0]         sbox_data_i,
  output logic                     rsp_valid_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_data_o,
  input  logic                     rsp_ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  // Arbitration state
  logic [ID_W-1:0]  rr_ptr;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_idx;
  int               cand;
  logic             issue;

  // Issue pipe: entry s describes the word issued s+1 cycles ago
  logic [LATENCY-1:0] pipe_valid;
  logic [ID_W-1:0]    pipe_id [LATENCY];

  // Response FIFO
  logic [ID_W-1:0]  fifo_id   [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  // Credit accounting
  logic [OUT_W-1:0] pipe_cnt;
  logic [OUT_W-1:0] outstanding;
  logic             credit_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign push       = pipe_valid[LATENCY-1];
  assign pop        = rsp_valid_o & rsp_ready_i;

  // Every word in flight already owns a FIFO slot. A pop this cycle frees
  // its slot early enough to back a new issue in the same cycle.
  always_comb begin
    pipe_cnt = '0;
    for (int s = 0; s < LATENCY; s++) begin
      pipe_cnt = pipe_cnt + OUT_W'(pipe_valid[s]);
    end
    outstanding = OUT_W'(count) + pipe_cnt;
    credit_ok   = (outstanding - OUT_W'(pop)) < OUT_W'(FIFO_DEPTH);
  end

  // Round-robin search: the first asserted valid at or after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_REQ;
      cand_idx = cand[ID_W-1:0];
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Reset also gates issue, so no accept is offered while rst_ni is low.
  assign issue = grant_found & credit_ok & rst_ni;

  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = issue && (grant_idx == ID_W'(k));
    end
    sbox_valid_o = issue;
    sbox_data_o  = issue ? req_data_i[int'(grant_idx)*WIDTH +: WIDTH] : '0;
  end

  // The head is forced to zero when the FIFO is empty.
  // The storage array has no reset, so this hides its stale contents.
  assign rsp_valid_o = !fifo_empty;
  assign rsp_id_o    = fifo_empty ? '0 : fifo_id[rd_ptr];
  assign rsp_data_o  = fifo_empty ? '0 : fifo_data[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      pipe_valid <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_id[s] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      // The datapath cannot stall, so the tag pipe shifts every cycle.
      pipe_valid[0] <= issue;
      pipe_id[0]    <= grant_idx;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_id[s]    <= pipe_id[s-1];
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id[wr_ptr]   <= pipe_id[LATENCY-1];
      fifo_data[wr_ptr] <= sbox_data_i;
    end
  end

  // Credit accounting must make an overflowing push impossible.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sbox_share_sched.sv
`timescale 1ns/1ps
module tb_sbox_share_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int LAT     = 2;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 2;
  localparam int EW      = ID_W + WIDTH;

  // ---------------------------------------------------------------- clock/reset
  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NUM_REQ-1:0]       req_valid_i = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     sbox_valid_o;
  logic [WIDTH-1:0]         sbox_data_o;
  logic [WIDTH-1:0]         sbox_data_i = '0;
  logic                     rsp_valid_o;
  logic [ID_W-1:0]          rsp_id_o;
  logic [WIDTH-1:0]         rsp_data_o;
  logic                     rsp_ready_i = 1'b1;

  always #5 clk_i = ~clk_i;

  sbox_share_sched #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .sbox_valid_o(sbox_valid_o), .sbox_data_o(sbox_data_o), .sbox_data_i(sbox_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_ready_i(rsp_ready_i)
  );

  initial begin
    #60000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- state
  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0]    exp_q[$];     // {id, expected result} in grant order
  int               acc_q[$];     // accept cycle of each exp_q entry
  int               cyc = 0;
  int               ptr_m = 0;    // reference round-robin pointer
  int               rem[NUM_REQ];
  logic [WIDTH-1:0] cur_data[NUM_REQ];
  logic [WIDTH-1:0] dp_sh[LAT];   // datapath model
  logic [WIDTH-1:0] dp_in = '0;
  int               rdy_mode = 1; // 0 low, 1 high, 2 random
  bit               rand_refill = 1'b0;
  bit               release_pending = 1'b0;
  int               dut_log[$];   // DUT grant indices, from req_ready_o

  // PRESENT S-box as the shared datapath function
  function automatic logic [3:0] sbox_f(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; 4'hF: return 4'h2;
      default: return 4'h0;
    endcase
  endfunction

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) r = (r < 0) ? k : 99;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic sample();
    bit            exp_rv;
    bit            pop_m;
    bit            credit;
    int            eg;
    int            c;
    int            tmp;
    logic [EW-1:0] head;
    exp_rv = (exp_q.size() > 0) && (cyc >= acc_q[0] + LAT + 1);
    check("rsp_valid", rsp_valid_o, exp_rv);
    if (exp_rv) begin
      head = exp_q[0];
      check("rsp_id", rsp_id_o, head[EW-1:WIDTH]);
      check("rsp_data", rsp_data_o, head[WIDTH-1:0]);
    end
    pop_m  = exp_rv && rsp_ready_i;
    credit = (exp_q.size() - int'(pop_m)) < DEPTH;
    eg = -1;
    if (credit) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        c = (ptr_m + i) % NUM_REQ;
        if (eg < 0 && req_valid_i[c]) eg = c;
      end
    end
    check("req_ready", req_ready_o, (eg >= 0) ? (32'd1 << eg) : 32'd0);
    check("sbox_valid", sbox_valid_o, eg >= 0);
    check("sbox_data", sbox_data_o, (eg >= 0) ? cur_data[eg] : 4'h0);
    dp_in = sbox_data_o;
    if (pop_m) begin
      head = exp_q.pop_front();
      tmp  = acc_q.pop_front();
    end
    if (eg >= 0) begin
      exp_q.push_back({ID_W'(eg), sbox_f(cur_data[eg])});
      acc_q.push_back(cyc);
      ptr_m = (eg + 1) % NUM_REQ;
      rem[eg]--;
      cur_data[eg] = 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk_i);
    #1;
    if (release_pending) begin
      rst_ni = 1'b1;
      release_pending = 1'b0;
    end
    for (int s = LAT - 1; s > 0; s--) dp_sh[s] = dp_sh[s-1];
    dp_sh[0] = dp_in;
    sbox_data_i = sbox_f(dp_sh[LAT-1]);
    if (rand_refill) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (rem[k] == 0 && $urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 3);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid_i[k] = (rem[k] > 0);
      req_data_i[k*WIDTH +: WIDTH] = cur_data[k];
    end
    case (rdy_mode)
      0:       rsp_ready_i = 1'b0;
      1:       rsp_ready_i = 1'b1;
      default: rsp_ready_i = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk_i);
    sample();
    cyc++;
  endtask

  // Steps n cycles, counting DUT grants and DUT response transfers.
  task automatic run(input int n, output int g_cnt, output int p_cnt);
    g_cnt = 0;
    p_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sbox_valid_o) begin
        g_cnt++;
        dut_log.push_back(oh_idx(req_ready_o));
      end
      if (rsp_valid_o && rsp_ready_i) p_cnt++;
    end
  endtask

  // Each requester still asserting valid sends exactly one more word.
  task automatic stop_reqs();
    for (int k = 0; k < NUM_REQ; k++) rem[k] = (rem[k] > 0) ? 1 : 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 0);
    check({tag, "_sbox_valid"}, sbox_valid_o, 0);
    check({tag, "_sbox_data"}, sbox_data_o, 0);
    check({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_rsp_id"}, rsp_id_o, 0);
    check({tag, "_rsp_data"}, rsp_data_o, 0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int g;
    int p;
    int t_acc;
    int t_rsp;
    int dut_cnt[NUM_REQ];
    int exp_seq[4];

    for (int k = 0; k < NUM_REQ; k++) begin
      rem[k] = 0;
      cur_data[k] = 4'($urandom_range(0, 15));
    end
    for (int s = 0; s < LAT; s++) dp_sh[s] = '0;

    // Reset with every requester asserting valid: no accept may be offered.
    req_valid_i = '1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs_zero("reset");
    release_pending = 1'b1;

    // Single request
    rem[0] = 1;
    cur_data[0] = 4'hA;
    t_acc = -1;
    t_rsp = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (t_acc < 0 && req_ready_o[0]) t_acc = cyc - 1;
      if (t_rsp < 0 && rsp_valid_o) t_rsp = cyc - 1;
    end
    check("single_latency", t_rsp - t_acc, LAT + 1);

    // Round-robin fairness, continuous load
    for (int k = 0; k < NUM_REQ; k++) begin
      rem[k] = 1000;
      dut_cnt[k] = 0;
    end
    dut_log.delete();
    run(16, g, p);
    check("rr_grants", g, 16);
    foreach (dut_log[i]) if (dut_log[i] >= 0 && dut_log[i] < NUM_REQ) dut_cnt[dut_log[i]]++;
    for (int k = 0; k < NUM_REQ; k++) check($sformatf("rr_share%0d", k), dut_cnt[k], 4);
    stop_reqs();
    run(12, g, p);

    // Pointer wrap and skip: reach pointer 3, then requesters 0 and 2
    dut_log.delete();
    rem[2] = 1;
    run(1, g, p);
    rem[0] = 1;
    rem[2] = 1;
    run(2, g, p);
    for (int k = 0; k < NUM_REQ; k++) rem[k] = 1;
    run(1, g, p);
    exp_seq = '{2, 0, 2, 3};
    check("wrap_len", dut_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < dut_log.size()) check($sformatf("wrap_seq%0d", i), dut_log[i], exp_seq[i]);
    run(12, g, p);

    // Async reset mid-flight: 2 words in the pipe, 2 in the FIFO
    rdy_mode = 0;
    for (int k = 0; k < NUM_REQ; k++) rem[k] = 1000;
    run(5, g, p);
    #1 rst_ni = 1'b0;
    #1 check_outputs_zero("async_rst");
    exp_q.delete();
    acc_q.delete();
    ptr_m = 0;
    release_pending = 1'b1;

    // Backpressure: exactly DEPTH grants, and the first goes to requester 0
    dut_log.delete();
    run(10, g, p);
    check("bp_grants", g, DEPTH);
    check("post_rst_first", (dut_log.size() > 0) ? dut_log[0] : -1, 0);
    rdy_mode = 1;
    run(1, g, p);
    check("bp_pop_grant", g, 1);
    check("bp_pop_cnt", p, 1);
    check("bp_pop_id", rsp_id_o, 0);
    rdy_mode = 0;
    run(LAT + 2, g, p);
    check("full_no_grant", g, 0);

    // Full FIFO, empty pipe: pop and push together every cycle
    rdy_mode = 1;
    run(8, g, p);
    check("full_stream_grants", g, 8);
    check("full_stream_pops", p, 8);

    // Random traffic and random backpressure
    rdy_mode = 2;
    rand_refill = 1'b1;
    run(300, g, p);
    rand_refill = 1'b0;
    stop_reqs();
    rdy_mode = 1;
    run(24, g, p);
    check("drained_rsp_valid", rsp_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
